// File: rtl/axi_master_line_reader_if.sv
// Bundle of the line-fetch request/response handshakes and the AXI AR/R
// channels; master = line reader, slave = requester plus AXI read slave.
interface axi_master_line_reader_if #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8,
  parameter int LINE_WORDS         = 8
);
  localparam int LW = LINE_WORDS * READ_CHANNEL_WIDTH;

  logic                          req_valid;
  logic                          req_ready;
  logic [ADDR_WIDTH-1:0]         req_addr;

  logic                          ARVALID;
  logic                          ARREADY;
  logic [ADDR_WIDTH-1:0]         ARADDR;
  logic [READ_BURST_LEN-1:0]     ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;

  logic                          RVALID;
  logic                          RREADY;
  logic [READ_CHANNEL_WIDTH-1:0] RDATA;
  logic                          RLAST;
  logic [1:0]                    RRESP;

  logic                          resp_valid;
  logic                          resp_ready;
  logic [LW-1:0]                 resp_line;
  logic                          resp_err;

  modport master (
    input  req_valid, req_addr,
    output req_ready,
    output ARVALID, ARADDR, ARLEN,
    output ARSIZE, ARBURST,
    input  ARREADY,
    input  RVALID, RDATA, RLAST, RRESP,
    output RREADY,
    output resp_valid, resp_line, resp_err,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_addr,
    input  req_ready,
    input  ARVALID, ARADDR, ARLEN,
    input  ARSIZE, ARBURST,
    output ARREADY,
    output RVALID, RDATA, RLAST, RRESP,
    input  RREADY,
    input  resp_valid, resp_line, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/axi_master_line_reader.sv
// Fetches one cache line per request as a single AXI INCR read burst.
// Ports: clk, rst_n (sync, active-high), bus (master: req/AR/R/resp).
module axi_master_line_reader #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8,
  parameter int LINE_WORDS         = 8
) (
  input  logic clk,
  input  logic rst_n,
  axi_master_line_reader_if.master bus
);
  localparam int W   = READ_CHANNEL_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFS = $clog2(LINE_WORDS * W / 8);

  localparam logic [AW-1:0] ALIGN =
    ~((AW'(1) << OFS) - AW'(1));
  localparam logic [CW-1:0] LAST =
    CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]           araddr;
  logic [CW-1:0]           cnt;
  logic [LINE_WORDS*W-1:0] line;
  logic                    err;

  logic accept;
  logic ar_done;
  logic beat;
  logic last_slot;
  logic done;
  logic beat_bad;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign ar_done   = (state == ADDR) && bus.ARREADY;
  assign beat      = (state == DATA) && bus.RVALID;
  assign last_slot = (cnt == LAST);
  // Burst ends on RLAST or on the final slot, whichever comes first.
  assign done      = beat && (bus.RLAST || last_slot);
  // Bad beat: error response, or RLAST not on exactly the final slot.
  assign beat_bad  = (bus.RRESP != 2'b00) ||
                     (bus.RLAST != last_slot);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)         state_nxt = ADDR;
      ADDR: if (ar_done)        state_nxt = DATA;
      DATA: if (done)           state_nxt = RESP;
      RESP: if (bus.resp_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.ARVALID    = 1'b0;
    bus.RREADY     = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE:    bus.req_ready  = 1'b1;
      ADDR:    bus.ARVALID    = 1'b1;
      DATA:    bus.RREADY     = 1'b1;
      RESP:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      araddr <= '0;
      cnt    <= '0;
      line   <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        araddr <= bus.req_addr & ALIGN;
        cnt    <= '0;
        err    <= 1'b0;
      end
      if (beat) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
          if (cnt == CW'(i)) begin
            line[i*W +: W] <= bus.RDATA;
          end
        end
        if (beat_bad) begin
          err <= 1'b1;
        end
        // Hold on the final slot so the count never wraps.
        if (!last_slot) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.ARADDR    = araddr;
  assign bus.ARLEN     =
    READ_BURST_LEN'(LINE_WORDS - 1);
  assign bus.ARSIZE    = 3'($clog2(W / 8));
  assign bus.ARBURST   = 2'b01;
  assign bus.resp_line = line;
  assign bus.resp_err  = err;
endmodule

// File: tb/tb_axi_master_line_reader.sv
// Randomised scoreboard bench for axi_master_line_reader: the bench plays
// requester and AXI slave, a monitor checks each returned line.
module tb_axi_master_line_reader;
  localparam int AW = 32;
  localparam int W  = 32;
  localparam int BL = 8;
  localparam int LN = 8;
  localparam int LW = LN * W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   hold_req = 1'b0;

  logic [W-1:0]  mline [LN];
  logic [LW-1:0] exp_line_q [$];
  logic          exp_err_q [$];
  logic [LW-1:0] el;
  logic          ee;

  axi_master_line_reader_if #(
    .ADDR_WIDTH(AW),
    .READ_CHANNEL_WIDTH(W),
    .READ_BURST_LEN(BL),
    .LINE_WORDS(LN)
  ) bus ();

  axi_master_line_reader #(
    .ADDR_WIDTH(AW),
    .READ_CHANNEL_WIDTH(W),
    .READ_BURST_LEN(BL),
    .LINE_WORDS(LN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_line();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < LN; i++) v[i*W +: W] = mline[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_line_q.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        el = exp_line_q.pop_front();
        ee = exp_err_q.pop_front();
        chk("resp_line", bus.resp_line, el);
        chk("resp_err", bus.resp_err, ee);
      end
    end
  end

  task automatic fetch(input logic [AW-1:0] addr,
                       input int ar_wait,
                       input int gap,
                       input int err_beat,
                       input int last_beat,
                       input int resp_wait,
                       input bit fixed,
                       input int abort_beat);
    logic [AW-1:0] exp_ar;
    logic [LW-1:0] lv;
    logic [W-1:0]  d;
    bit acc;
    bit fin;
    bit merr;
    bit ev;
    int a;
    int n;
    exp_ar = addr & ~AW'(LN * W / 8 - 1);
    merr = 1'b0;
    acc = 1'b0;
    a = 0;
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.req_ready;
      a = cyc;
      @(posedge clk); #1;
    end
    if (!hold_req) bus.req_valid = 1'b0;
    if (!acc) begin
      chk("req_accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    for (int i = 0; i < ar_wait; i++) begin
      bus.RVALID = 1'b1;
      bus.RDATA = $urandom;
      @(negedge clk);
      chk("arvalid_hold", bus.ARVALID, 1);
      chk("araddr_hold", bus.ARADDR, exp_ar);
      chk("rready_outside", bus.RREADY, 0);
      chk("req_ready_busy", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    bus.RVALID = 1'b0;
    bus.ARREADY = 1'b1;
    @(negedge clk);
    chk("arvalid", bus.ARVALID, 1);
    chk("araddr", bus.ARADDR, exp_ar);
    chk("arlen", bus.ARLEN, LN - 1);
    chk("arsize", bus.ARSIZE, 2);
    chk("arburst", bus.ARBURST, 1);
    @(posedge clk); #1;
    bus.ARREADY = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < LN && !fin; k++) begin
      if ((gap == 1 && k % 2 == 1) ||
          (gap == 2 && $urandom_range(0, 2) == 0)) begin
        bus.RVALID = 1'b0;
        @(negedge clk);
        chk("rready_gap", bus.RREADY, 1);
        chk("req_ready_busy", bus.req_ready, 0);
        @(posedge clk); #1;
      end
      d = fixed ? W'(32'hA0 + k) : W'($urandom);
      bus.RVALID = 1'b1;
      bus.RDATA = d;
      bus.RRESP = (k == err_beat) ? 2'b10 : 2'b00;
      bus.RLAST = (k == last_beat);
      @(negedge clk);
      chk("rready_beat", bus.RREADY, 1);
      @(posedge clk); #1;
      mline[k] = d;
      if (k == err_beat) merr = 1'b1;
      if (k == last_beat) begin
        fin = 1'b1;
        if (k != LN - 1) merr = 1'b1;
      end else if (k == LN - 1) begin
        merr = 1'b1;
      end
      if (k == abort_beat) begin
        bus.RVALID = 1'b0;
        bus.RLAST = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < LN; i++) mline[i] = '0;
        @(negedge clk);
        chk("abort_arvalid", bus.ARVALID, 0);
        chk("abort_rready", bus.RREADY, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_resp_err", bus.resp_err, 0);
        chk("abort_line", bus.resp_line, '0);
        @(posedge clk); #1;
        return;
      end
    end
    bus.RVALID = 1'b0;
    bus.RLAST = 1'b0;
    bus.RRESP = 2'b00;
    exp_line_q.push_back(pack_line());
    exp_err_q.push_back(merr);
    @(negedge clk);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) begin
      chk("resp_timeout", 0, 1);
      void'(exp_line_q.pop_back());
      void'(exp_err_q.pop_back());
      return;
    end
    if (ar_wait == 0 && gap == 0 && last_beat == LN - 1)
      chk("resp_latency", cyc - a, 10);
    lv = bus.resp_line;
    ev = bus.resp_err;
    chk("req_ready_resp", bus.req_ready, 0);
    for (int i = 0; i < resp_wait; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("resp_valid_hold", bus.resp_valid, 1);
      chk("resp_line_hold", bus.resp_line, lv);
      chk("resp_err_hold", bus.resp_err, ev);
      chk("no_ar_in_resp", bus.ARVALID, 0);
      chk("req_ready_resp", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int eb;
    int lb;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.ARREADY = 1'b0;
    bus.RVALID = 1'b0;
    bus.RDATA = '0;
    bus.RLAST = 1'b0;
    bus.RRESP = 2'b00;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < LN; i++) mline[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_rready", bus.RREADY, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_araddr", bus.ARADDR, 0);
    chk("rst_line", bus.resp_line, '0);
    @(posedge clk); #1;

    fetch(32'h0000_0044, 0, 0, -1, 7, 0, 1'b1, -1);
    fetch(32'h0000_1238, 5, 1, -1, 7, 3, 1'b0, -1);
    fetch(32'h0000_0080, 0, 0, 3, 7, 1, 1'b0, -1);
    fetch(32'h0000_00C4, 0, 0, -1, 7, 0, 1'b0, -1);
    fetch(32'h0000_0200, 0, 0, -1, 5, 0, 1'b0, -1);
    fetch(32'h0000_0240, 0, 0, -1, -1, 0, 1'b0, -1);
    fetch(32'h0000_0300, 0, 0, -1, 7, 0, 1'b0, 2);
    fetch(32'h0000_0100, 0, 0, -1, 7, 0, 1'b0, -1);
    hold_req = 1'b1;
    fetch(32'h0000_0000, 0, 0, -1, 7, 2, 1'b0, -1);
    hold_req = 1'b0;
    fetch(32'h0000_0020, 0, 0, -1, 7, 0, 1'b0, -1);

    for (int r = 0; r < 25; r++) begin
      eb = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, LN - 1)) : -1;
      lb = LN - 1;
      if ($urandom_range(0, 3) == 0) begin
        lb = int'($urandom_range(0, LN));
        if (lb == LN) lb = -1;
      end
      fetch($urandom,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)),
            eb, lb,
            int'($urandom_range(0, 3)),
            1'b0, -1);
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drain", exp_line_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
